// File: rtl/fetch_sequencer.sv
// Program store plus PC sequencer feeding the opcode decoder.
// Burst-loaded memory; each instruction takes one FETCH and one EXEC cycle.
module fetch_sequencer #(
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] HALT_WORD = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_en,
    input  logic [7:0]        prog_data,
    input  logic              run,
    input  logic              bez,
    input  logic              ja,
    input  logic              zero,
    output logic [2:0]        opcode,
    output logic [4:0]        operand,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              loading
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [7:0]        instr_q, instr_d;

    logic [7:0]        mem [0:DEPTH-1];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        fetch_word;
    logic [ADDR_W-1:0] branch_target;

    assign fetch_word    = mem[pc_q];
    // Operand bits above the address width only matter as immediates.
    assign branch_target = instr_q[ADDR_W-1:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wr_ptr_d  = wr_ptr_q;
        instr_d   = instr_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (prog_en) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    wr_ptr_d  = ADDR_W'(1);
                    state_d   = S_LOAD;
                end else if (run) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_LOAD: begin
                if (prog_en) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                instr_d = fetch_word;
                state_d = (fetch_word == HALT_WORD) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (ja || (bez && zero)) begin
                    pc_d = branch_target;
                end else begin
                    pc_d = pc_q + ADDR_W'(1);
                end
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                if (!run) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            wr_ptr_q <= '0;
            instr_q  <= HALT_WORD;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            instr_q  <= instr_d;
        end
    end

    // Program contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= prog_data;
        end
    end

    assign instr_valid = (state_q == S_EXEC);
    assign opcode      = instr_valid ? instr_q[7:5] : 3'b111;
    assign operand     = instr_q[4:0];
    assign pc          = pc_q;
    assign halted      = (state_q == S_HALT);
    assign loading     = (state_q == S_LOAD);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; a tiny decoder model drives bez/ja
// from the presented opcode (000 = bez, 010 = ja).
module tb_fetch_sequencer;

    logic       clk;
    logic       rst_n;
    logic       prog_en;
    logic [7:0] prog_data;
    logic       run;
    logic       bez;
    logic       ja;
    logic       zero;
    logic [2:0] opcode;
    logic [4:0] operand;
    logic       instr_valid;
    logic [3:0] pc;
    logic       halted;
    logic       loading;

    int checks = 0;
    int errors = 0;
    logic [7:0] prog [0:16];

    fetch_sequencer #(.ADDR_W(4), .HALT_WORD(8'hFF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prog_en     (prog_en),
        .prog_data   (prog_data),
        .run         (run),
        .bez         (bez),
        .ja          (ja),
        .zero        (zero),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted),
        .loading     (loading)
    );

    assign bez = instr_valid && (opcode == 3'b000);
    assign ja  = instr_valid && (opcode == 3'b010);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) begin
            prog_en   = 1'b1;
            prog_data = prog[i];
            tick();
            check($sformatf("loading_w%0d", i), 32'(loading), 32'd1);
        end
        prog_en = 1'b0;
        tick();
        check("loading_done", 32'(loading), 32'd0);
    endtask

    // One FETCH cycle then one EXEC cycle at the given pc.
    task automatic exec_step(input logic [2:0] op, input logic [4:0] opnd, input logic [3:0] p);
        tick();
        check("fetch_valid", 32'(instr_valid), 32'd0);
        check("fetch_opcode", 32'(opcode), 32'd7);
        check("fetch_pc", 32'(pc), 32'(p));
        tick();
        check("exec_valid", 32'(instr_valid), 32'd1);
        check("exec_opcode", 32'(opcode), 32'(op));
        check("exec_operand", 32'(operand), 32'(opnd));
        check("exec_pc", 32'(pc), 32'(p));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; prog_en = 1'b0; prog_data = 8'h00; run = 1'b0; zero = 1'b0;
        tick(); tick();
        check("rst_opcode", 32'(opcode), 32'd7);
        check("rst_operand", 32'(operand), 32'h1F);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_loading", 32'(loading), 32'd0);
        rst_n = 1'b1;
        tick();

        // Load and sequence to halt
        prog[0] = 8'h21; prog[1] = 8'h62; prog[2] = 8'h83; prog[3] = 8'hFF;
        load_prog(4);
        run = 1'b1;
        exec_step(3'b001, 5'h01, 4'd0);
        exec_step(3'b011, 5'h02, 4'd1);
        exec_step(3'b100, 5'h03, 4'd2);
        tick();
        check("seq_fetch_halt_pc", 32'(pc), 32'd3);
        tick();
        check("seq_halted", 32'(halted), 32'd1);
        check("seq_halt_pc", 32'(pc), 32'd3);
        check("seq_halt_opcode", 32'(opcode), 32'd7);
        run = 1'b0;
        tick();
        check("seq_idle_halted", 32'(halted), 32'd0);

        // Branch taken / not taken
        prog[0] = 8'h05; prog[1] = 8'hFF; prog[2] = 8'h00;
        prog[3] = 8'h00; prog[4] = 8'h00; prog[5] = 8'hFF;
        load_prog(6);
        zero = 1'b1; run = 1'b1;
        exec_step(3'b000, 5'h05, 4'd0);
        tick();
        check("bez_taken_pc", 32'(pc), 32'd5);
        tick();
        check("bez_taken_halt", 32'(halted), 32'd1);
        run = 1'b0; tick();
        zero = 1'b0; run = 1'b1;
        exec_step(3'b000, 5'h05, 4'd0);
        tick();
        check("bez_not_taken_pc", 32'(pc), 32'd1);
        tick();
        check("bez_not_taken_halt", 32'(halted), 32'd1);
        run = 1'b0; tick();

        // Jump with wrap from 15 back to 0
        prog[0] = 8'h4F;
        for (int i = 1; i < 15; i++) prog[i] = 8'hFF;
        prog[15] = 8'h60;
        load_prog(16);
        run = 1'b1;
        exec_step(3'b010, 5'h0F, 4'd0);
        exec_step(3'b011, 5'h00, 4'd15);
        exec_step(3'b010, 5'h0F, 4'd0);
        exec_step(3'b011, 5'h00, 4'd15);
        exec_step(3'b010, 5'h0F, 4'd0);

        // Run dropped in EXEC: pc still updates, then IDLE
        run = 1'b0;
        tick();
        check("drop_valid", 32'(instr_valid), 32'd0);
        check("drop_pc", 32'(pc), 32'd15);
        check("drop_halted", 32'(halted), 32'd0);
        prog_en = 1'b1; prog_data = 8'h4F; run = 1'b1;
        tick();
        check("prio_loading", 32'(loading), 32'd1);
        check("prio_pc", 32'(pc), 32'd15);
        prog_en = 1'b0; run = 1'b0;
        tick();
        check("prio_idle", 32'(loading), 32'd0);

        // Load wrap: 17 words, word 16 lands on address 0
        for (int i = 0; i < 17; i++) prog[i] = 8'(i);
        load_prog(17);
        zero = 1'b0; run = 1'b1;
        exec_step(3'b000, 5'h10, 4'd0);
        exec_step(3'b000, 5'h01, 4'd1);

        // Async reset between edges in EXEC
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_opcode", 32'(opcode), 32'd7);
        check("areset_valid", 32'(instr_valid), 32'd0);
        check("areset_pc", 32'(pc), 32'd0);
        tick();
        rst_n = 1'b1;
        exec_step(3'b000, 5'h10, 4'd0);
        exec_step(3'b000, 5'h01, 4'd1);
        run = 1'b0;
        tick();
        check("final_pc", 32'(pc), 32'd2);
        check("final_valid", 32'(instr_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
